// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing constants and types for the video timing sequencer
//
// Holds the default horizontal timing, the bit positions of the flags in the
// vertical-timing PROM nibble, and the 8-bit scan line type.
package video_timing_pkg;

   localparam int HTOTAL_DEF       = 384;
   localparam int HBLANK_START_DEF = 256;
   localparam int HSYNC_START_DEF  = 288;
   localparam int HSYNC_END_DEF    = 320;

   // Bit 3 of the PROM nibble carries nothing for this block.
   localparam int VT_BIT_VBLANK = 2;
   localparam int VT_BIT_VSYNC  = 1;
   localparam int VT_BIT_VMARK  = 0;

   typedef logic [7:0] line_t;

endpackage

// File: rtl/video_hcounter.sv
// rtl/video_hcounter.sv - horizontal pixel counter with hblank/hsync decode
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   pix_ce          pixel clock enable; the counter only moves when it is high
//   hcount          horizontal position, 0..HTOTAL-1
//   hblank, hsync   registered decodes that line up with hcount
//   line_wrap       combinational strobe, high on the enabled clk where hcount
//                   returns from HTOTAL-1 to 0
module video_hcounter
   import video_timing_pkg::*;
#(
   parameter int HTOTAL       = HTOTAL_DEF,
   parameter int HBLANK_START = HBLANK_START_DEF,
   parameter int HSYNC_START  = HSYNC_START_DEF,
   parameter int HSYNC_END    = HSYNC_END_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_ce,
   output logic [8:0] hcount,
   output logic       hblank,
   output logic       hsync,
   output logic       line_wrap
);

   // Compares are done at 10 bits so HSYNC_END/HTOTAL may equal 512.
   localparam logic [9:0] HLAST  = 10'(HTOTAL - 1);
   localparam logic [9:0] HB_S   = 10'(HBLANK_START);
   localparam logic [9:0] HS_S   = 10'(HSYNC_START);
   localparam logic [9:0] HS_E   = 10'(HSYNC_END);
   localparam bit PARAMS_LEGAL   = (HBLANK_START < HSYNC_START) &&
                                   (HSYNC_START < HSYNC_END) &&
                                   (HSYNC_END <= HTOTAL) &&
                                   (HTOTAL <= 512);

   logic [8:0] hcount_next;
   logic [9:0] hnext_w;

   always_comb begin
      line_wrap = pix_ce && ({1'b0, hcount} == HLAST);
      if (!pix_ce) begin
         hcount_next = hcount;
      end else if (line_wrap) begin
         hcount_next = '0;
      end else begin
         hcount_next = hcount + 9'd1;
      end
      hnext_w = {1'b0, hcount_next};
   end

   // hblank/hsync are decoded from the value hcount is about to take, so the
   // registered flags describe the same pixel as the registered count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount <= '0;
         hblank <= 1'b0;
         hsync  <= 1'b0;
      end else if (pix_ce) begin
         hcount <= hcount_next;
         hblank <= (hnext_w >= HB_S);
         hsync  <= (hnext_w >= HS_S) && (hnext_w < HS_E);
      end
   end

   param_legal: assert property (@(posedge clk) PARAMS_LEGAL);

endmodule

// File: rtl/video_vtiming_seq.sv
// rtl/video_vtiming_seq.sv - video timing sequencer driving the vertical-timing PROM
//
// Optional feature macro: VTIMING_VINT_EN (one-clk vint pulse on a rising vmark).
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   pix_ce          pixel clock enable
//   prom_a, prom_e  PROM address (always vcount+1) and enable (1 out of reset)
//   prom_d          registered PROM nibble {unused, vblank, vsync, vmark}
//   hcount, vcount  scan position
//   hblank, hsync   horizontal decodes
//   vblank, vsync,  vertical flags latched from the PROM at each line wrap,
//   vmark           describing the line vcount has just moved to
//   vint            interrupt pulse (0 unless VTIMING_VINT_EN)
module video_vtiming_seq
   import video_timing_pkg::*;
#(
   parameter int HTOTAL       = HTOTAL_DEF,
   parameter int HBLANK_START = HBLANK_START_DEF,
   parameter int HSYNC_START  = HSYNC_START_DEF,
   parameter int HSYNC_END    = HSYNC_END_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_ce,
   output logic [7:0] prom_a,
   output logic       prom_e,
   input  logic [3:0] prom_d,
   output logic [8:0] hcount,
   output logic [7:0] vcount,
   output logic       hblank,
   output logic       hsync,
   output logic       vblank,
   output logic       vsync,
   output logic       vmark,
   output logic       vint
);

   logic  line_wrap;
   line_t vline;
   logic  prom_d3_unused;

   assign prom_d3_unused = prom_d[3];
   assign vcount         = vline;

   video_hcounter #(
      .HTOTAL       (HTOTAL),
      .HBLANK_START (HBLANK_START),
      .HSYNC_START  (HSYNC_START),
      .HSYNC_END    (HSYNC_END)
   ) u_hcounter (
      .clk       (clk),
      .reset     (reset),
      .pix_ce    (pix_ce),
      .hcount    (hcount),
      .hblank    (hblank),
      .hsync     (hsync),
      .line_wrap (line_wrap)
   );

   // The PROM is addressed one line ahead, so by the time a line wraps its
   // data has been sitting on prom_d for most of a line and is latched
   // together with the new vcount.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vline  <= '0;
         prom_a <= 8'h01;
         prom_e <= 1'b0;
         vblank <= 1'b0;
         vsync  <= 1'b0;
         vmark  <= 1'b0;
      end else begin
         prom_e <= 1'b1;
         if (line_wrap) begin
            vline  <= vline + 8'd1;
            prom_a <= vline + 8'd2;
            vblank <= prom_d[VT_BIT_VBLANK];
            vsync  <= prom_d[VT_BIT_VSYNC];
            vmark  <= prom_d[VT_BIT_VMARK];
         end
      end
   end

`ifdef VTIMING_VINT_EN
   logic vint_q;

   // The latched vmark itself is the edge-detect history: the pulse is raised
   // on the wrap that loads a 1 into a vmark currently holding 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vint_q <= 1'b0;
      end else begin
         vint_q <= line_wrap && prom_d[VT_BIT_VMARK] && !vmark;
      end
   end

   assign vint = vint_q;
`else
   assign vint = 1'b0;
`endif

endmodule
